// File: rtl/bti_meas_seq_if.sv
// Control/status bundle between the register bank, the BTI sensor and bti_meas_seq.
// The master side drives run requests, lengths and the raw RO signal; the slave is the sequencer.
interface bti_meas_seq_if #(
  parameter int CNT_W = 32,
  parameter int TIM_W = 32
);
  logic             start;
  logic             abort;
  logic [TIM_W-1:0] stress_cycles;
  logic [7:0]       settle_cycles;
  logic [TIM_W-1:0] meas_cycles;
  logic             ro_in;
  logic             stress_en;
  logic             ro_en;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [CNT_W-1:0] ro_count;
  logic             overflow;
  logic [7:0]       meas_id;

  modport master (
    output start, abort, stress_cycles, settle_cycles, meas_cycles, ro_in,
    input  stress_en, ro_en, busy, done, result_valid, ro_count, overflow, meas_id
  );

  modport slave (
    input  start, abort, stress_cycles, settle_cycles, meas_cycles, ro_in,
    output stress_en, ro_en, busy, done, result_valid, ro_count, overflow, meas_id
  );
endinterface

// File: rtl/bti_meas_seq.sv
// BTI sensor measurement sequencer: stress, settle and measure phases with a
// saturating ring-oscillator edge counter whose result is reported to the register bank.
module bti_meas_seq #(
  parameter int CNT_W       = 32,
  parameter int TIM_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic           ACLK,
  input logic           ARESET,
  bti_meas_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_STRESS, S_SETTLE, S_MEASURE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [TIM_W-1:0] r_cnt, w_cntNext;
  logic [TIM_W-1:0] r_stressLen, r_measLen;
  logic [7:0]       r_settleLen;
  logic [TIM_W-1:0] w_stressLen, w_settleLen, w_measLen;
  logic             w_accept;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_rise;
  logic [CNT_W-1:0]       r_acc, w_accNext;
  logic                   r_ovf, w_ovfNext;

  logic             r_stressEn, r_roEn, r_busy, r_done, r_resultValid, r_overflow;
  logic [CNT_W-1:0] r_roCount;
  logic [7:0]       r_measId;

  function automatic state_t pickPhase(input logic useStress, input logic useSettle,
                                       input logic useMeas);
    if (useStress)      return S_STRESS;
    else if (useSettle) return S_SETTLE;
    else if (useMeas)   return S_MEASURE;
    else                return S_DONE;
  endfunction

  // In IDLE the live inputs decide the first phase, since they are latched on that same edge.
  assign w_stressLen = (r_state == S_IDLE) ? bus.stress_cycles : r_stressLen;
  assign w_settleLen = TIM_W'((r_state == S_IDLE) ? bus.settle_cycles : r_settleLen);
  assign w_measLen   = (r_state == S_IDLE) ? bus.meas_cycles : r_measLen;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_accept = 1'b1;
          w_next   = pickPhase(w_stressLen != '0, w_settleLen != '0, w_measLen != '0);
        end
      end
      S_STRESS: begin
        if (bus.abort)        w_next = S_IDLE;
        else if (r_cnt == '0) w_next = pickPhase(1'b0, w_settleLen != '0, w_measLen != '0);
      end
      S_SETTLE: begin
        if (bus.abort)        w_next = S_IDLE;
        else if (r_cnt == '0) w_next = pickPhase(1'b0, 1'b0, w_measLen != '0);
      end
      S_MEASURE: begin
        if (bus.abort)        w_next = S_IDLE;
        else if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Down-counter holds remaining cycles minus one; it is reloaded on every state change.
  always_comb begin
    w_cntNext = r_cnt;
    if (w_next != r_state) begin
      case (w_next)
        S_STRESS:  w_cntNext = w_stressLen - TIM_W'(1);
        S_SETTLE:  w_cntNext = w_settleLen - TIM_W'(1);
        S_MEASURE: w_cntNext = w_measLen - TIM_W'(1);
        default:   w_cntNext = '0;
      endcase
    end else if (r_state == S_STRESS || r_state == S_SETTLE || r_state == S_MEASURE) begin
      w_cntNext = r_cnt - TIM_W'(1);
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

  always_comb begin
    w_accNext = r_acc;
    w_ovfNext = r_ovf;
    if (w_accept) begin
      w_accNext = '0;
      w_ovfNext = 1'b0;
    end else if (r_state == S_MEASURE && w_rise) begin
      if (r_acc == {CNT_W{1'b1}}) w_ovfNext = 1'b1;
      else                        w_accNext = r_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stressLen <= '0;
      r_settleLen <= '0;
      r_measLen   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_stressLen <= bus.stress_cycles;
        r_settleLen <= bus.settle_cycles;
        r_measLen   <= bus.meas_cycles;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sync <= '0;
      r_edge <= 1'b0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ro_in};
      r_edge <= r_sync[SYNC_STAGES-1];
      r_acc  <= w_accNext;
      r_ovf  <= w_ovfNext;
    end
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_stressEn    <= 1'b0;
      r_roEn        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_resultValid <= 1'b0;
      r_roCount     <= '0;
      r_overflow    <= 1'b0;
      r_measId      <= '0;
    end else begin
      r_stressEn <= (w_next == S_STRESS);
      r_roEn     <= (w_next == S_SETTLE) || (w_next == S_MEASURE);
      r_busy     <= (w_next == S_STRESS) || (w_next == S_SETTLE) || (w_next == S_MEASURE);
      r_done     <= (w_next == S_DONE);
      if (w_accept) r_resultValid <= 1'b0;
      if (w_next == S_DONE) begin
        r_resultValid <= 1'b1;
        r_roCount     <= w_accNext;
        r_overflow    <= w_ovfNext;
        r_measId      <= r_measId + 8'd1;
      end
    end
  end

  assign bus.stress_en    = r_stressEn;
  assign bus.ro_en        = r_roEn;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_resultValid;
  assign bus.ro_count     = r_roCount;
  assign bus.overflow     = r_overflow;
  assign bus.meas_id      = r_measId;

endmodule

// File: tb/tb_bti_meas_seq.sv
// Directed bench for bti_meas_seq: phase timing, edge counting, saturation,
// abort, interference and asynchronous reset, with hand-computed expectations.
module tb_bti_meas_seq;

  logic ACLK;
  logic ARESET;

  bti_meas_seq_if #(.CNT_W(4), .TIM_W(32)) bus ();

  bti_meas_seq #(.CNT_W(4), .TIM_W(32), .SYNC_STAGES(2)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  int stFirst, stLast, roFirst, roLast, bzFirst, bzLast;
  int doneCnt, doneAt, overlap;
  logic rvAtDone;

  int roMode    = 0;
  int roCnt     = 0;
  int burstLeft = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // RO source: mode 1 is free-running with a 10-cycle period, mode 2 emits burstLeft pulses of 6 cycles.
  initial begin
    bus.ro_in = 1'b0;
    forever begin
      @(negedge ACLK);
      if (roMode == 1) begin
        roCnt++;
        if (roCnt >= 5) begin
          roCnt = 0;
          bus.ro_in = ~bus.ro_in;
        end
      end else if (roMode == 2 && burstLeft > 0) begin
        roCnt++;
        if (roCnt >= 3) begin
          roCnt = 0;
          bus.ro_in = ~bus.ro_in;
          if (bus.ro_in == 1'b0) burstLeft--;
        end
      end else begin
        roCnt = 0;
        bus.ro_in = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge ACLK);
  endtask

  // Issues a start and observes cycles 1..n after it; poke adds ignored start pulses mid-run and in DONE.
  task automatic applyStimulus(input int n, input bit poke, input int midMeas);
    stFirst = -1; stLast = -1; roFirst = -1; roLast = -1; bzFirst = -1; bzLast = -1;
    doneCnt = 0; doneAt = -1; overlap = 0; rvAtDone = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.stress_en) begin if (stFirst < 0) stFirst = c; stLast = c; end
      if (bus.ro_en)     begin if (roFirst < 0) roFirst = c; roLast = c; end
      if (bus.busy)      begin if (bzFirst < 0) bzFirst = c; bzLast = c; end
      if (bus.stress_en && bus.ro_en) overlap++;
      if (bus.done) begin
        doneCnt++;
        doneAt   = c;
        rvAtDone = bus.result_valid;
      end
      if (midMeas > 0 && c == 3) bus.meas_cycles = midMeas;
      if (poke && c == 5) bus.start = 1'b1;
      if (poke && bus.done) bus.start = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    ARESET            = 1'b1;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.stress_cycles = '0;
    bus.settle_cycles = '0;
    bus.meas_cycles   = '0;
    step();
    step();
    checkOutput("rst_stress_en", 32'(bus.stress_en), 0);
    checkOutput("rst_ro_en", 32'(bus.ro_en), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_result_valid", 32'(bus.result_valid), 0);
    checkOutput("rst_ro_count", 32'(bus.ro_count), 0);
    checkOutput("rst_overflow", 32'(bus.overflow), 0);
    checkOutput("rst_meas_id", 32'(bus.meas_id), 0);
    ARESET = 1'b0;
    step();

    $display("[TB] basic run");
    bus.stress_cycles = 10; bus.settle_cycles = 4; bus.meas_cycles = 100; roMode = 1;
    applyStimulus(120, 1'b1, 0);
    checkOutput("basic_stress_first", stFirst, 1);
    checkOutput("basic_stress_last", stLast, 10);
    checkOutput("basic_ro_first", roFirst, 11);
    checkOutput("basic_ro_last", roLast, 114);
    checkOutput("basic_busy_first", bzFirst, 1);
    checkOutput("basic_busy_last", bzLast, 114);
    checkOutput("basic_done_count", doneCnt, 1);
    checkOutput("basic_done_at", doneAt, 115);
    checkOutput("basic_overlap", overlap, 0);
    checkOutput("basic_rv_at_done", 32'(rvAtDone), 1);
    checkOutput("basic_count_9to11", 32'(bus.ro_count >= 4'd9 && bus.ro_count <= 4'd11), 1);
    checkOutput("basic_overflow", 32'(bus.overflow), 0);
    checkOutput("basic_result_valid", 32'(bus.result_valid), 1);
    checkOutput("basic_meas_id", 32'(bus.meas_id), 1);

    $display("[TB] measure only, meas_cycles changed mid-run");
    bus.stress_cycles = 0; bus.settle_cycles = 0; bus.meas_cycles = 50;
    applyStimulus(55, 1'b0, 5);
    checkOutput("meas_ro_first", roFirst, 1);
    checkOutput("meas_ro_last", roLast, 50);
    checkOutput("meas_stress_never", stFirst, -1);
    checkOutput("meas_done_at", doneAt, 51);
    checkOutput("meas_meas_id", 32'(bus.meas_id), 2);

    $display("[TB] all-zero lengths");
    roMode = 0;
    bus.meas_cycles = 0;
    applyStimulus(5, 1'b0, 0);
    checkOutput("zero_done_at", doneAt, 1);
    checkOutput("zero_busy_never", bzFirst, -1);
    checkOutput("zero_ro_count", 32'(bus.ro_count), 0);
    checkOutput("zero_meas_id", 32'(bus.meas_id), 3);

    $display("[TB] saturation");
    roMode = 1;
    bus.meas_cycles = 400;
    applyStimulus(405, 1'b0, 0);
    checkOutput("sat_done_at", doneAt, 401);
    checkOutput("sat_ro_count", 32'(bus.ro_count), 15);
    checkOutput("sat_overflow", 32'(bus.overflow), 1);
    checkOutput("sat_meas_id", 32'(bus.meas_id), 4);

    $display("[TB] five-edge burst after saturation");
    roMode = 0;
    step();
    step();
    roMode = 2; burstLeft = 5;
    bus.meas_cycles = 100;
    applyStimulus(105, 1'b0, 0);
    checkOutput("burst_done_at", doneAt, 101);
    checkOutput("burst_ro_count", 32'(bus.ro_count), 5);
    checkOutput("burst_overflow", 32'(bus.overflow), 0);
    checkOutput("burst_meas_id", 32'(bus.meas_id), 5);

    $display("[TB] start with abort in IDLE");
    roMode = 1;
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    checkOutput("sa_busy_now", 32'(bus.busy), 0);
    step(); step(); step();
    checkOutput("sa_busy_later", 32'(bus.busy), 0);
    checkOutput("sa_result_valid", 32'(bus.result_valid), 1);
    checkOutput("sa_meas_id", 32'(bus.meas_id), 5);

    $display("[TB] abort in MEASURE");
    bus.meas_cycles = 100;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 2; c <= 20; c++) step();
    checkOutput("abort_ro_en_before", 32'(bus.ro_en), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checkOutput("abort_ro_en_after", 32'(bus.ro_en), 0);
    checkOutput("abort_busy_after", 32'(bus.busy), 0);
    checkOutput("abort_no_done", 32'(bus.done), 0);
    checkOutput("abort_result_valid", 32'(bus.result_valid), 0);
    checkOutput("abort_ro_count", 32'(bus.ro_count), 5);
    checkOutput("abort_overflow", 32'(bus.overflow), 0);
    checkOutput("abort_meas_id", 32'(bus.meas_id), 5);
    bus.meas_cycles = 20;
    applyStimulus(25, 1'b0, 0);
    checkOutput("restart_busy_first", bzFirst, 1);
    checkOutput("restart_done_at", doneAt, 21);
    checkOutput("restart_done_count", doneCnt, 1);
    checkOutput("restart_meas_id", 32'(bus.meas_id), 6);

    $display("[TB] reset during STRESS");
    bus.stress_cycles = 50; bus.meas_cycles = 10;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    checkOutput("ares_stress_before", 32'(bus.stress_en), 1);
    #2 ARESET = 1'b1;
    #1;
    checkOutput("ares_stress_en", 32'(bus.stress_en), 0);
    checkOutput("ares_busy", 32'(bus.busy), 0);
    checkOutput("ares_result_valid", 32'(bus.result_valid), 0);
    checkOutput("ares_ro_count", 32'(bus.ro_count), 0);
    checkOutput("ares_meas_id", 32'(bus.meas_id), 0);
    step();
    ARESET = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
